// File: rtl/pipe_ctrl.sv
// Control unit for the 5-stage miniRV pipeline: ID decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use stall, redirect flush and EX forwarding. Optional macro FORWARD_EN.
module pipe_ctrl #(
    parameter int INST_W = 32,
    parameter int RA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INST_W-1:0] id_inst,
    input  logic              id_valid,
    input  logic              ex_br_true,
    output logic              stall_o,
    output logic              flush_o,
    output logic              id_illegal_o,
    output logic [2:0]        ex_sext_op,
    output logic [1:0]        ex_npc_op,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alub_sel,
    output logic [2:0]        ex_br_op,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              mem_ram_we,
    output logic [1:0]        mem_rf_wsel,
    output logic              wb_rf_we,
    output logic [1:0]        wb_rf_wsel,
    output logic [RA_W-1:0]   wb_rd
);
    localparam logic [2:0] SEXT_I = 3'b000, SEXT_S = 3'b001, SEXT_B = 3'b010;
    localparam logic [2:0] SEXT_U = 3'b011, SEXT_J = 3'b100, SEXT_NONE = 3'b111;
    localparam logic [1:0] NPC_JAL = 2'b01, NPC_BR = 2'b10, NPC_JALR = 2'b11;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010, ALU_OR = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100, ALU_SLL = 3'b101, ALU_SRL = 3'b110, ALU_SRA = 3'b111;
    localparam logic [1:0] WSEL_ALU = 2'b00, WSEL_RAM = 2'b01, WSEL_PC4 = 2'b10, WSEL_IMM = 2'b11;
    localparam logic [2:0] BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_BLT = 3'b010, BR_BGE = 3'b011;
    localparam logic [2:0] BR_NONE = 3'b111;

    typedef struct packed {
        logic            valid;
        logic [2:0]      sext_op;
        logic [1:0]      npc_op;
        logic [2:0]      alu_op;
        logic            alub_sel;
        logic [2:0]      br_op;
        logic            ram_we;
        logic            rf_we;
        logic [1:0]      rf_wsel;
        logic [RA_W-1:0] rd;
`ifdef FORWARD_EN
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
`endif
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic            ram_we;
        logic            rf_we;
        logic [1:0]      rf_wsel;
        logic [RA_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic            valid;
        logic            rf_we;
        logic [1:0]      rf_wsel;
        logic [RA_W-1:0] rd;
    } wb_t;

    function automatic ctrl_t ctrl_bubble();
        ctrl_t b;
        b         = '0;
        b.sext_op = SEXT_NONE;
        b.br_op   = BR_NONE;
        return b;
    endfunction

    // Does a writer to rd collide with a source register the ID instruction actually reads?
    function automatic logic rs_hit(input logic [RA_W-1:0] rd, input logic [RA_W-1:0] rs1,
                                    input logic [RA_W-1:0] rs2, input logic u1, input logic u2);
        return (rd != '0) && ((u1 && rd == rs1) || (u2 && rd == rs2));
    endfunction

    ctrl_t idex_q, idex_d, id_ctrl;
    mem_t  exmem_q, exmem_d;
    wb_t   memwb_q, memwb_d;

    logic [6:0]      id_opcode, id_f7;
    logic [2:0]      id_f3, alu_f3;
    logic [RA_W-1:0] id_rd, id_rs1, id_rs2;
    logic            id_legal, id_use1, id_use2, alu_f3_ok;
    logic            redirect, stall_raw;

    assign id_opcode = id_inst[6:0];
    assign id_f3     = id_inst[14:12];
    assign id_f7     = id_inst[31:25];
    assign id_rd     = id_inst[7 +: RA_W];
    assign id_rs1    = id_inst[15 +: RA_W];
    assign id_rs2    = id_inst[20 +: RA_W];

    // funct3 -> ALU op shared by R-type and OP-IMM; funct7[5] picks arithmetic right shift
    always_comb begin
        alu_f3    = ALU_ADD;
        alu_f3_ok = 1'b1;
        case (id_f3)
            3'b000:  alu_f3 = ALU_ADD;
            3'b111:  alu_f3 = ALU_AND;
            3'b110:  alu_f3 = ALU_OR;
            3'b100:  alu_f3 = ALU_XOR;
            3'b001:  alu_f3 = ALU_SLL;
            3'b101:  alu_f3 = id_f7[5] ? ALU_SRA : ALU_SRL;
            default: alu_f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        id_ctrl  = ctrl_bubble();
        id_legal = 1'b0;
        id_use1  = 1'b0;
        id_use2  = 1'b0;
        case (id_opcode)
            7'b0110011: begin
                id_legal = alu_f3_ok && (id_f7 == 7'h00 ||
                           (id_f7 == 7'h20 && (id_f3 == 3'b000 || id_f3 == 3'b101)));
                id_ctrl.alu_op = (id_f3 == 3'b000 && id_f7[5]) ? ALU_SUB : alu_f3;
                id_ctrl.rf_we  = 1'b1;
                id_ctrl.rd     = id_rd;
                id_use1 = 1'b1;
                id_use2 = 1'b1;
            end
            7'b0010011: begin
                id_legal = alu_f3_ok && ((id_f3 != 3'b001 && id_f3 != 3'b101) || id_f7 == 7'h00 ||
                           (id_f3 == 3'b101 && id_f7 == 7'h20));
                id_ctrl.sext_op  = SEXT_I;
                id_ctrl.alu_op   = alu_f3;
                id_ctrl.alub_sel = 1'b1;
                id_ctrl.rf_we    = 1'b1;
                id_ctrl.rd       = id_rd;
                id_use1 = 1'b1;
            end
            7'b0000011: begin
                id_legal = (id_f3 == 3'b010);
                id_ctrl.sext_op  = SEXT_I;
                id_ctrl.alub_sel = 1'b1;
                id_ctrl.rf_we    = 1'b1;
                id_ctrl.rf_wsel  = WSEL_RAM;
                id_ctrl.rd       = id_rd;
                id_use1 = 1'b1;
            end
            7'b0100011: begin
                id_legal = (id_f3 == 3'b010);
                id_ctrl.sext_op  = SEXT_S;
                id_ctrl.alub_sel = 1'b1;
                id_ctrl.ram_we   = 1'b1;
                id_use1 = 1'b1;
                id_use2 = 1'b1;
            end
            7'b1100011: begin
                id_legal = (id_f3 == 3'b000 || id_f3 == 3'b001 || id_f3 == 3'b100 || id_f3 == 3'b101);
                id_ctrl.sext_op = SEXT_B;
                id_ctrl.npc_op  = NPC_BR;
                id_ctrl.alu_op  = ALU_SUB;
                case (id_f3)
                    3'b000:  id_ctrl.br_op = BR_BEQ;
                    3'b001:  id_ctrl.br_op = BR_BNE;
                    3'b100:  id_ctrl.br_op = BR_BLT;
                    default: id_ctrl.br_op = BR_BGE;
                endcase
                id_use1 = 1'b1;
                id_use2 = 1'b1;
            end
            7'b0110111: begin
                id_legal = 1'b1;
                id_ctrl.sext_op  = SEXT_U;
                id_ctrl.alub_sel = 1'b1;
                id_ctrl.rf_we    = 1'b1;
                id_ctrl.rf_wsel  = WSEL_IMM;
                id_ctrl.rd       = id_rd;
            end
            7'b1101111: begin
                id_legal = 1'b1;
                id_ctrl.sext_op = SEXT_J;
                id_ctrl.npc_op  = NPC_JAL;
                id_ctrl.rf_we   = 1'b1;
                id_ctrl.rf_wsel = WSEL_PC4;
                id_ctrl.rd      = id_rd;
            end
            7'b1100111: begin
                id_legal = (id_f3 == 3'b000);
                id_ctrl.sext_op  = SEXT_I;
                id_ctrl.npc_op   = NPC_JALR;
                id_ctrl.alub_sel = 1'b1;
                id_ctrl.rf_we    = 1'b1;
                id_ctrl.rf_wsel  = WSEL_PC4;
                id_ctrl.rd       = id_rd;
                id_use1 = 1'b1;
            end
            default: id_legal = 1'b0;
        endcase
        if (id_valid && id_legal) begin
            id_ctrl.valid = 1'b1;
        end else begin
            id_ctrl = ctrl_bubble();
            id_use1 = 1'b0;
            id_use2 = 1'b0;
        end
`ifdef FORWARD_EN
        // Unused sources are stored as x0 so they can never pick up a forward
        id_ctrl.rs1 = id_use1 ? id_rs1 : '0;
        id_ctrl.rs2 = id_use2 ? id_rs2 : '0;
`endif
    end

    assign id_illegal_o = id_valid && !id_legal;
    assign redirect = idex_q.valid && (idex_q.npc_op == NPC_JAL || idex_q.npc_op == NPC_JALR ||
                                       (idex_q.npc_op == NPC_BR && ex_br_true));
    assign flush_o  = redirect;

`ifdef FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] rs, input mem_t m, input wb_t w);
        if (m.valid && m.rf_we && m.rd != '0 && m.rd == rs) return 2'b01;
        if (w.valid && w.rf_we && w.rd != '0 && w.rd == rs) return 2'b10;
        return 2'b00;
    endfunction

    assign stall_raw = id_valid && idex_q.valid && idex_q.rf_wsel == WSEL_RAM &&
                       rs_hit(idex_q.rd, id_rs1, id_rs2, id_use1, id_use2);
    assign ex_fwd_a  = fwd_sel(idex_q.rs1, exmem_q, memwb_q);
    assign ex_fwd_b  = fwd_sel(idex_q.rs2, exmem_q, memwb_q);
`else
    // Without a bypass network the consumer waits until every pending writer has left WB
    assign stall_raw = id_valid && (
        (idex_q.valid  && idex_q.rf_we  && rs_hit(idex_q.rd,  id_rs1, id_rs2, id_use1, id_use2)) ||
        (exmem_q.valid && exmem_q.rf_we && rs_hit(exmem_q.rd, id_rs1, id_rs2, id_use1, id_use2)) ||
        (memwb_q.valid && memwb_q.rf_we && rs_hit(memwb_q.rd, id_rs1, id_rs2, id_use1, id_use2)));
    assign ex_fwd_a  = 2'b00;
    assign ex_fwd_b  = 2'b00;
`endif

    assign stall_o = stall_raw && !redirect;

    always_comb begin
        idex_d          = (redirect || stall_raw) ? ctrl_bubble() : id_ctrl;
        exmem_d         = '0;
        exmem_d.valid   = idex_q.valid;
        exmem_d.ram_we  = idex_q.ram_we;
        exmem_d.rf_we   = idex_q.rf_we;
        exmem_d.rf_wsel = idex_q.rf_wsel;
        exmem_d.rd      = idex_q.rd;
        memwb_d         = '0;
        memwb_d.valid   = exmem_q.valid;
        memwb_d.rf_we   = exmem_q.rf_we;
        memwb_d.rf_wsel = exmem_q.rf_wsel;
        memwb_d.rd      = exmem_q.rd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= ctrl_bubble();
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
        end
    end

    assign ex_sext_op  = idex_q.sext_op;
    assign ex_npc_op   = idex_q.npc_op;
    assign ex_alu_op   = idex_q.alu_op;
    assign ex_alub_sel = idex_q.alub_sel;
    assign ex_br_op    = idex_q.br_op;
    assign mem_ram_we  = exmem_q.ram_we;
    assign mem_rf_wsel = exmem_q.rf_wsel;
    assign wb_rf_we    = memwb_q.rf_we;
    assign wb_rf_wsel  = memwb_q.rf_wsel;
    assign wb_rd       = memwb_q.rd;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a decode table walked through all stages, then
// hand-written hazard, flush, illegal and reset sequences (expectations follow FORWARD_EN).
module tb_pipe_ctrl;
`ifdef FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_br_true;
    logic [31:0] id_inst;
    logic        stall_o, flush_o, id_illegal_o, ex_alub_sel, mem_ram_we, wb_rf_we;
    logic [2:0]  ex_sext_op, ex_alu_op, ex_br_op;
    logic [1:0]  ex_npc_op, ex_fwd_a, ex_fwd_b, mem_rf_wsel, wb_rf_wsel;
    logic [4:0]  wb_rd;

    pipe_ctrl #(.INST_W(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid), .ex_br_true(ex_br_true),
        .stall_o(stall_o), .flush_o(flush_o), .id_illegal_o(id_illegal_o),
        .ex_sext_op(ex_sext_op), .ex_npc_op(ex_npc_op), .ex_alu_op(ex_alu_op),
        .ex_alub_sel(ex_alub_sel), .ex_br_op(ex_br_op), .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .mem_ram_we(mem_ram_we), .mem_rf_wsel(mem_rf_wsel), .wb_rf_we(wb_rf_we),
        .wb_rf_wsel(wb_rf_wsel), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        ill;
        logic [2:0]  sext;
        logic [1:0]  npc;
        logic [2:0]  alu;
        logic        alub;
        logic [2:0]  br;
        logic        flush;
        logic        ram_we;
        logic        rf_we;
        logic [1:0]  wsel;
        logic [4:0]  rd;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; id_valid = 1'b0; ex_br_true = 1'b0; id_inst = 32'h0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Present an instruction in ID, hold it while stalled (bounded), and let it advance into EX
    task automatic issue(input logic [31:0] inst, output int nstall);
        id_inst = inst; id_valid = 1'b1; nstall = 0;
        @(negedge clk);
        while (stall_o && nstall < 8) begin
            tick();
            nstall++;
            @(negedge clk);
        end
        tick();
        id_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] inst, input logic ill, input logic [2:0] sext,
                                input logic [1:0] npc, input logic [2:0] alu, input logic alub,
                                input logic [2:0] br, input logic flush, input logic ram_we,
                                input logic rf_we, input logic [1:0] wsel, input logic [4:0] rd);
        vec_t v;
        v.inst = inst; v.ill = ill; v.sext = sext; v.npc = npc; v.alu = alu; v.alub = alub;
        v.br = br; v.flush = flush; v.ram_we = ram_we; v.rf_we = rf_we; v.wsel = wsel; v.rd = rd;
        return v;
    endfunction

    vec_t vt[23];
    int   ns, ram_seen;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = mk(32'h002081B3, 0, 3'b111, 2'b00, 3'b000, 0, 3'b111, 0, 0, 1, 2'b00, 5'd3); // add
        vt[1]  = mk(32'h402083B3, 0, 3'b111, 2'b00, 3'b001, 0, 3'b111, 0, 0, 1, 2'b00, 5'd7); // sub
        vt[2]  = mk(32'h0020F1B3, 0, 3'b111, 2'b00, 3'b010, 0, 3'b111, 0, 0, 1, 2'b00, 5'd3); // and
        vt[3]  = mk(32'h0020E1B3, 0, 3'b111, 2'b00, 3'b011, 0, 3'b111, 0, 0, 1, 2'b00, 5'd3); // or
        vt[4]  = mk(32'h0020C1B3, 0, 3'b111, 2'b00, 3'b100, 0, 3'b111, 0, 0, 1, 2'b00, 5'd3); // xor
        vt[5]  = mk(32'h002091B3, 0, 3'b111, 2'b00, 3'b101, 0, 3'b111, 0, 0, 1, 2'b00, 5'd3); // sll
        vt[6]  = mk(32'h0020D1B3, 0, 3'b111, 2'b00, 3'b110, 0, 3'b111, 0, 0, 1, 2'b00, 5'd3); // srl
        vt[7]  = mk(32'h4020D1B3, 0, 3'b111, 2'b00, 3'b111, 0, 3'b111, 0, 0, 1, 2'b00, 5'd3); // sra
        vt[8]  = mk(32'h00018213, 0, 3'b000, 2'b00, 3'b000, 1, 3'b111, 0, 0, 1, 2'b00, 5'd4); // addi
        vt[9]  = mk(32'hFFF1C213, 0, 3'b000, 2'b00, 3'b100, 1, 3'b111, 0, 0, 1, 2'b00, 5'd4); // xori
        vt[10] = mk(32'h4011D213, 0, 3'b000, 2'b00, 3'b111, 1, 3'b111, 0, 0, 1, 2'b00, 5'd4); // srai
        vt[11] = mk(32'h0000A283, 0, 3'b000, 2'b00, 3'b000, 1, 3'b111, 0, 0, 1, 2'b01, 5'd5); // lw
        vt[12] = mk(32'h0020A223, 0, 3'b001, 2'b00, 3'b000, 1, 3'b111, 0, 1, 0, 2'b00, 5'd0); // sw
        vt[13] = mk(32'h00208463, 0, 3'b010, 2'b10, 3'b001, 0, 3'b000, 0, 0, 0, 2'b00, 5'd0); // beq
        vt[14] = mk(32'h00209463, 0, 3'b010, 2'b10, 3'b001, 0, 3'b001, 0, 0, 0, 2'b00, 5'd0); // bne
        vt[15] = mk(32'h0020C463, 0, 3'b010, 2'b10, 3'b001, 0, 3'b010, 0, 0, 0, 2'b00, 5'd0); // blt
        vt[16] = mk(32'h0020D463, 0, 3'b010, 2'b10, 3'b001, 0, 3'b011, 0, 0, 0, 2'b00, 5'd0); // bge
        vt[17] = mk(32'h12345437, 0, 3'b011, 2'b00, 3'b000, 1, 3'b111, 0, 0, 1, 2'b11, 5'd8); // lui
        vt[18] = mk(32'h008000EF, 0, 3'b100, 2'b01, 3'b000, 0, 3'b111, 1, 0, 1, 2'b10, 5'd1); // jal
        vt[19] = mk(32'h004084E7, 0, 3'b000, 2'b11, 3'b000, 1, 3'b111, 1, 0, 1, 2'b10, 5'd9); // jalr
        vt[20] = mk(32'hFFFFFFFF, 1, 3'b111, 2'b00, 3'b000, 0, 3'b111, 0, 0, 0, 2'b00, 5'd0); // junk
        vt[21] = mk(32'h802081B3, 1, 3'b111, 2'b00, 3'b000, 0, 3'b111, 0, 0, 0, 2'b00, 5'd0); // bad f7
        vt[22] = mk(32'h00008283, 1, 3'b111, 2'b00, 3'b000, 0, 3'b111, 0, 0, 0, 2'b00, 5'd0); // lb

        // Reset held two cycles with a live instruction on the input
        rst = 1'b1; id_valid = 1'b1; id_inst = 32'h0000A283; ex_br_true = 1'b1;
        tick(); tick();
        @(negedge clk);
        chk("rst wb_rf_we", wb_rf_we, 0);
        chk("rst mem_ram_we", mem_ram_we, 0);
        chk("rst ex_br_op", ex_br_op, 3'b111);
        chk("rst ex_sext_op", ex_sext_op, 3'b111);
        chk("rst stall_o", stall_o, 0);
        chk("rst flush_o", flush_o, 0);
        chk("rst ex_fwd_a", ex_fwd_a, 2'b00);
        $display("reset: wb_rf_we=%0d mem_ram_we=%0d ex_br_op=%b", wb_rf_we, mem_ram_we, ex_br_op);
        do_reset();

        // Each vector is walked ID -> EX -> MEM -> WB, then drained before the next one
        for (int i = 0; i < 23; i++) begin
            id_inst = vt[i].inst; id_valid = 1'b1; ex_br_true = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d illegal", i), id_illegal_o, vt[i].ill);
            chk($sformatf("v%0d id stall", i), stall_o, 0);
            tick();
            id_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d sext", i), ex_sext_op, vt[i].sext);
            chk($sformatf("v%0d npc", i), ex_npc_op, vt[i].npc);
            chk($sformatf("v%0d alu", i), ex_alu_op, vt[i].alu);
            chk($sformatf("v%0d alub", i), ex_alub_sel, vt[i].alub);
            chk($sformatf("v%0d br", i), ex_br_op, vt[i].br);
            chk($sformatf("v%0d flush", i), flush_o, vt[i].flush);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d ram_we", i), mem_ram_we, vt[i].ram_we);
            chk($sformatf("v%0d mem_wsel", i), mem_rf_wsel, vt[i].wsel);
            tick();
            @(negedge clk);
            chk($sformatf("v%0d rf_we", i), wb_rf_we, vt[i].rf_we);
            chk($sformatf("v%0d wb_wsel", i), wb_rf_wsel, vt[i].wsel);
            chk($sformatf("v%0d rd", i), wb_rd, vt[i].rd);
            tick();
            $display("vec %0d inst=%h illegal=%0d alu=%b sext=%b wb_rd=%0d",
                     i, vt[i].inst, vt[i].ill, vt[i].alu, vt[i].sext, vt[i].rd);
        end

        // add x3,x1,x2 ; addi x4,x3,0
        do_reset();
        issue(32'h002081B3, ns);
        issue(32'h00018213, ns);
        chk("raw stall cycles", ns, FWD ? 0 : 3);
        @(negedge clk);
        chk("raw fwd_a", ex_fwd_a, FWD ? 2'b01 : 2'b00);
        chk("raw fwd_b", ex_fwd_b, 2'b00);
        chk("raw alu", ex_alu_op, 3'b000);
        chk("raw alub", ex_alub_sel, 1);
        $display("raw pair: stalls=%0d fwd_a=%b", ns, ex_fwd_a);

        // add x3 ; xor x3 ; addi x4,x3,0 -> nearest producer wins
        do_reset();
        issue(32'h002081B3, ns);
        issue(32'h0020C1B3, ns);
        issue(32'h00018213, ns);
        chk("prio stall cycles", ns, FWD ? 0 : 3);
        @(negedge clk);
        chk("prio fwd_a", ex_fwd_a, FWD ? 2'b01 : 2'b00);
        $display("priority: stalls=%0d fwd_a=%b", ns, ex_fwd_a);

        // add x0,x1,x2 ; addi x4,x0,0 -> x0 is neither a hazard nor forwarded
        do_reset();
        issue(32'h00208033, ns);
        issue(32'h00000213, ns);
        chk("x0 stall cycles", ns, 0);
        @(negedge clk);
        chk("x0 fwd_a", ex_fwd_a, 2'b00);
        $display("x0 pair: stalls=%0d fwd_a=%b", ns, ex_fwd_a);

        // lw x5,0(x1) ; add x6,x5,x5
        do_reset();
        issue(32'h0000A283, ns);
        id_inst = 32'h00528333; id_valid = 1'b1;
        @(negedge clk);
        chk("lu first stall", stall_o, 1);
        tick();
        @(negedge clk);
        chk("lu bubble in EX", ex_sext_op, 3'b111);
        chk("lu bubble br_op", ex_br_op, 3'b111);
        ns = 1;
        while (stall_o && ns < 8) begin
            tick();
            ns++;
            @(negedge clk);
        end
        chk("lu stall cycles", ns, FWD ? 1 : 3);
        tick();
        id_valid = 1'b0;
        @(negedge clk);
        chk("lu fwd_a", ex_fwd_a, FWD ? 2'b10 : 2'b00);
        chk("lu fwd_b", ex_fwd_b, FWD ? 2'b10 : 2'b00);
        chk("lu consumer in EX", ex_sext_op, 3'b111);
        chk("lu consumer alub", ex_alub_sel, 0);
        $display("load-use: stalls=%0d fwd_a=%b fwd_b=%b", ns, ex_fwd_a, ex_fwd_b);

        // lw x5 ; beq taken in EX while add x6,x5,x5 sits in ID
        do_reset();
        issue(32'h0000A283, ns);
        issue(32'h00208463, ns);
        id_inst = 32'h00528333; id_valid = 1'b1; ex_br_true = 1'b1;
        @(negedge clk);
        chk("fs flush_o", flush_o, 1);
        chk("fs stall_o", stall_o, 0);
        tick();
        id_valid = 1'b0; ex_br_true = 1'b0;
        @(negedge clk);
        chk("fs bubble in EX", ex_sext_op, 3'b111);
        chk("fs flush clears", flush_o, 0);
        chk("fs lw reaches WB", wb_rf_we, 1);
        chk("fs lw rd", wb_rd, 5'd5);
        tick(); tick();
        @(negedge clk);
        chk("fs squashed wb_rf_we", wb_rf_we, 0);
        chk("fs squashed wb_rd", wb_rd, 5'd0);
        $display("flush+stall: flush honoured, squashed slot wb_rf_we=%0d", wb_rf_we);

        // Illegal instruction never produces a write
        do_reset();
        id_inst = 32'hFFFFFFFF; id_valid = 1'b1;
        @(negedge clk);
        chk("ill flag", id_illegal_o, 1);
        tick();
        id_valid = 1'b0;
        ram_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (mem_ram_we) ram_seen++;
            if (c < 2) tick();
        end
        chk("ill wb_rf_we", wb_rf_we, 0);
        chk("ill ram_we seen", ram_seen, 0);
        $display("illegal: id_illegal_o seen, ram writes=%0d", ram_seen);

        // Reset in mid-flight: sw in MEM, add in EX
        do_reset();
        issue(32'h0020A223, ns);
        issue(32'h002081B3, ns);
        @(negedge clk);
        chk("mid sw in MEM", mem_ram_we, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid ram_we", mem_ram_we, 0);
        chk("mid wb_rf_we", wb_rf_we, 0);
        chk("mid ex_br_op", ex_br_op, 3'b111);
        tick(); tick();
        @(negedge clk);
        chk("mid no late write", wb_rf_we, 0);
        $display("mid-reset: in-flight sw/add discarded");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
